// File: rtl/baud_pkg.sv
// baud_pkg: shared state type and constants for the baud tick generator.
package baud_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } baud_state_t;

    localparam int unsigned BAUD_CNT_W            = 16;
    localparam int unsigned BAUD_FRAC_W           = 4;
    localparam int unsigned BAUD_DIV_115200_12M   = 104;
    localparam int unsigned BAUD_DIV_9600_12M     = 1250;
    localparam int unsigned BAUD_PHASE_115200_12M = 52;

endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional-divisor accumulator. At every period wrap it adds
// the fractional part; a carry-out stretches the period starting at that wrap
// by one cycle. Only instantiated when BAUD_FRAC_EN is defined.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int unsigned FRAC_W = BAUD_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              extend
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    // Accumulator plus the fractional part, with the carry in the top bit.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, frac};
    end

    // Advance at each wrap; the carry marks the period that starts there as long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            extend <= 1'b0;
        end else if (clear) begin
            acc    <= '0;
            extend <= 1'b0;
        end else if (step) begin
            acc    <= sum[FRAC_W-1:0];
            extend <= sum[FRAC_W];
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: runtime-programmable baud/bit-timing generator. One period
// counter yields a period-start tick and a programmable-phase mid_tick.
// Divisor/phase reload through a valid/ready port and take effect only at a
// period boundary (or restart, or in IDLE). Optional fractional divisor is
// enabled with the BAUD_FRAC_EN macro (adds the cfg_frac port).
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W       = BAUD_CNT_W,
    parameter int unsigned DIV_RESET   = BAUD_DIV_115200_12M,
    parameter int unsigned PHASE_RESET = BAUD_PHASE_115200_12M,
    parameter int unsigned FRAC_W      = BAUD_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] cfg_frac,
`endif
    output logic              tick,
    output logic              mid_tick,
    output logic              busy
);

    baud_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_phase;
    logic             pending;

    logic [CNT_W-1:0] apply_div;
    logic [CNT_W-1:0] apply_phase;
    logic [CNT_W-1:0] next_div;
    logic [CNT_W-1:0] last_cnt;
    logic             running;
    logic             wrap;
    logic             accept;
    logic             apply;
    logic             extend;

    // Boundary detection, handshake and clamped values for the shadow config.
    always_comb begin
        running     = (state == RUN) && enable;
        last_cnt    = div_q - CNT_W'(1) + CNT_W'(extend);
        wrap        = (cnt == last_cnt);
        accept      = cfg_valid && !pending;
        // A falling enable defers the apply to the first IDLE cycle.
        apply       = pending && ((state == IDLE) || (running && (wrap || restart)));
        apply_div   = (sh_div < CNT_W'(2)) ? CNT_W'(2) : sh_div;
        apply_phase = (sh_phase >= apply_div) ? (apply_div - CNT_W'(1)) : sh_phase;
        next_div    = apply ? apply_div : div_q;
    end

    // Outputs decode registered state only.
    always_comb begin
        cfg_ready = !pending;
        busy      = (state == RUN);
        tick      = (state == RUN) && (cnt == '0);
        mid_tick  = (state == RUN) && (cnt == phase_q);
    end

    // Run/idle state, period counter, config shadow and apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= CNT_W'(DIV_RESET - 1);
            div_q    <= CNT_W'(DIV_RESET);
            phase_q  <= CNT_W'(PHASE_RESET);
            sh_div   <= '0;
            sh_phase <= '0;
            pending  <= 1'b0;
        end else begin
            if (accept) begin
                sh_div   <= cfg_div;
                sh_phase <= cfg_phase;
                pending  <= 1'b1;
            end else if (apply) begin
                div_q   <= apply_div;
                phase_q <= apply_phase;
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= next_div - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= div_q - CNT_W'(1);
                    end else if (restart || wrap) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] next_frac;
    logic              acc_clear;
    logic              acc_step;

    // A config applied at a wrap already contributes its fraction at that wrap.
    always_comb begin
        next_frac = apply ? sh_frac : frac_q;
        acc_clear = (state == IDLE) || (running && restart);
        acc_step  = running && wrap && !restart;
    end

    // Fractional part shadowed and applied together with the divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_frac <= '0;
            frac_q  <= '0;
        end else if (accept) begin
            sh_frac <= cfg_frac;
        end else if (apply) begin
            frac_q <= sh_frac;
        end
    end

    baud_frac_acc #(
        .FRAC_W(FRAC_W)
    ) u_frac_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear),
        .step  (acc_step),
        .frac  (next_frac),
        .extend(extend)
    );
`else
    // Without the accumulator the period never stretches.
    localparam logic [FRAC_W-1:0] NO_FRAC = '0;
    assign extend = |NO_FRAC;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: self-checking bench for baud_tick_gen.
module tb_baud_tick_gen;
    import baud_pkg::*;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam int          LIMIT  = 3000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             restart;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_phase;
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] cfg_frac;
`endif
    logic             tick;
    logic             mid_tick;
    logic             busy;

    baud_tick_gen #(
        .CNT_W      (CNT_W),
        .DIV_RESET  (104),
        .PHASE_RESET(52),
        .FRAC_W     (FRAC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .restart  (restart),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
`ifdef BAUD_FRAC_EN
        .cfg_frac (cfg_frac),
`endif
        .tick     (tick),
        .mid_tick (mid_tick),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int period;
        int mid;
    } exp_t;

    typedef struct {
        int div;
        int phase;
        int exp_div;
        int exp_phase;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Step at least once, then until tick (or the bound runs out).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < LIMIT);
        if (!tick) n = -1;
    endtask

    // Starting on a tick cycle: cycles to the next tick and mid_tick offset.
    task automatic measure(output int period, output int mid);
        int n;
        n      = 0;
        period = -1;
        mid    = mid_tick ? 0 : -1;
        while (n < LIMIT) begin
            step();
            n++;
            if (tick) begin
                period = n;
                break;
            end
            if (mid_tick && mid < 0) mid = n;
        end
    endtask

    task automatic sb_check(input string name, output int period);
        exp_t e;
        int   m;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 0, 1);
            period = -1;
            return;
        end
        e = sb.pop_front();
        measure(period, m);
        check({name, " period"}, period, e.period);
        check({name, " mid"}, m, e.mid);
    endtask

    task automatic offer(input int div, input int phase, input int frac);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(div);
        cfg_phase = CNT_W'(phase);
`ifdef BAUD_FRAC_EN
        cfg_frac  = FRAC_W'(frac);
`else
        if (frac != 0) $display("note: fractional part ignored in this build");
`endif
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p, early, seen, sum;

        vecs[0] = '{div: 1,    phase: 7,   exp_div: 2,    exp_phase: 1};
        vecs[1] = '{div: 0,    phase: 0,   exp_div: 2,    exp_phase: 0};
        vecs[2] = '{div: 6,    phase: 6,   exp_div: 6,    exp_phase: 5};
        vecs[3] = '{div: 5,    phase: 0,   exp_div: 5,    exp_phase: 0};
        vecs[4] = '{div: 12,   phase: 20,  exp_div: 12,   exp_phase: 11};
        vecs[5] = '{div: int'(BAUD_DIV_9600_12M), phase: 625,
                    exp_div: int'(BAUD_DIV_9600_12M), exp_phase: 625};
        vecs[6] = '{div: 104,  phase: 52,  exp_div: 104,  exp_phase: 52};

        rst_n     = 1'b0;
        enable    = 1'b0;
        restart   = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_phase = '0;
`ifdef BAUD_FRAC_EN
        cfg_frac  = '0;
`endif
        #12;
        check("reset tick", int'(tick), 0);
        check("reset mid_tick", int'(mid_tick), 0);
        check("reset busy", int'(busy), 0);
        check("reset cfg_ready", int'(cfg_ready), 1);
        step();
        rst_n = 1'b1;
        step_n(2);
        check("idle busy", int'(busy), 0);

        // Enable: tick one cycle after the sampling edge, default 104/52.
        enable = 1'b1;
        step();
        check("enable latency tick", int'(tick), 1);
        check("enable busy", int'(busy), 1);
        sb.push_back('{period: 104, mid: 52});
        sb_check("default", p);

        // Config mid-period: current period completes, ready low until apply.
        step_n(20);
        check("ready before offer", int'(cfg_ready), 1);
        offer(10, 3, 0);
        check("ready after accept", int'(cfg_ready), 0);
        n = 0;
        early = 0;
        while (n < 200) begin
            step();
            n++;
            if (tick) break;
            if (cfg_ready) early++;
        end
        check("cycles to apply", n, 83);
        check("ready early", early, 0);
        check("ready at apply", int'(cfg_ready), 1);
        sb.push_back('{period: 10, mid: 3});
        sb.push_back('{period: 10, mid: 3});
        sb_check("div10 first", p);
        sb_check("div10 second", p);

        // Table of configs, including clamping corners.
        for (int i = 0; i < 7; i++) begin
            offer(vecs[i].div, vecs[i].phase, 0);
            sb.push_back('{period: vecs[i].exp_div, mid: vecs[i].exp_phase});
            wait_tick(n);
            sb_check($sformatf("vec%0d", i), p);
        end

        // Restart mid-period.
        step_n(40);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart tick", int'(tick), 1);
        sb.push_back('{period: 104, mid: 52});
        sb_check("after restart", p);

        // Restart coinciding with a wrap and a pending config: applied once.
        offer(104, 30, 0);
        step_n(102);
        check("tick before wrap", int'(tick), 0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart at wrap tick", int'(tick), 1);
        check("restart at wrap ready", int'(cfg_ready), 1);
        sb.push_back('{period: 104, mid: 30});
        sb_check("restart at wrap", p);

        // Enable low for 5 cycles (restart ignored while idle).
        enable = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (tick || mid_tick || busy) seen++;
            restart = (i == 2);
            step();
            restart = 1'b0;
        end
        check("outputs while disabled", seen, 0);
        enable = 1'b1;
        step();
        check("re-enable tick", int'(tick), 1);
        check("re-enable busy", int'(busy), 1);
        sb.push_back('{period: 104, mid: 30});
        sb_check("re-enable", p);

        // Enable falling with a pending config: apply in the first IDLE cycle.
        step_n(10);
        offer(20, 5, 0);
        enable = 1'b0;
        step();
        check("pending ready in idle", int'(cfg_ready), 0);
        check("pending busy in idle", int'(busy), 0);
        step();
        check("applied in idle ready", int'(cfg_ready), 1);
        enable = 1'b1;
        step();
        check("idle apply tick", int'(tick), 1);
        sb.push_back('{period: 20, mid: 5});
        sb_check("idle apply", p);

        // Asynchronous reset mid-run.
        step_n(5);
        check("mid before reset", int'(mid_tick), 1);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("async reset mid_tick", int'(mid_tick), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset tick", int'(tick), 0);
        check("async reset ready", int'(cfg_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        enable = 1'b1;
        step();
        check("post reset tick", int'(tick), 1);
        sb.push_back('{period: 104, mid: 52});
        sb_check("post reset", p);

`ifdef BAUD_FRAC_EN
        // Fractional divisor 10 + 8/16: periods alternate 10, 11.
        offer(10, 3, 8);
        for (int i = 0; i < 16; i++) sb.push_back('{period: 10 + (i % 2), mid: 3});
        wait_tick(n);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            sb_check($sformatf("frac period %0d", i), p);
            sum += p;
        end
        check("frac 16 periods", sum, 168);
`else
        sum = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
